dac_dsp_serializer: RTL and testbench

//  Serializes 16-bit PCM samples into the WM8731 DSP-mode DAC stream (BCLK, DAC_LR_CLK, DAC_DATA).

---
 rtl/dac_pkg.sv | 10 +
 rtl/dac_dsp_serializer_if.sv | 16 +
 rtl/dac_bclk_gen.sv | 54 +++++
 rtl/dac_dsp_serializer.sv | 106 ++++++++++
 tb/tb_dac_dsp_serializer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_pkg.sv
// Shared defaults and the sample type for the WM8731 DSP-mode DAC serializer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dac_pkg;
    localparam int DATA_W_DEF     = 16;
    localparam int FRAME_BITS_DEF = 32;
    localparam int BCLK_HALF_DEF  = 2;

    typedef logic [DATA_W_DEF-1:0] sample_t;
endpackage

// File: rtl/dac_dsp_serializer_if.sv
// Sample stream into the DAC serializer: one mono PCM word per transfer.
// Latency: n/a (signal bundle only).
// Backpressure: valid/ready; a word moves in a cycle with s_valid && s_ready.
// Signals: s_data (two's complement sample), s_valid (source), s_ready (serializer).
interface dac_dsp_serializer_if
    import dac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/dac_bclk_gen.sv
// BCLK generator: clock-enable divider, bit counter and frame wrap strobe.
// Latency: bclk toggles every BCLK_HALF clk cycles while run=1; fall_en/frame_wrap are combinational.
// Backpressure: none; run=0 holds divider, bclk and bit_cnt at 0.
// Ports: clk, reset (async, active-low), run in; bclk, fall_en, frame_wrap, bit_cnt out.
module dac_bclk_gen
    import dac_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int BCLK_HALF  = BCLK_HALF_DEF
)(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    output logic                          bclk,
    output logic                          fall_en,
    output logic                          frame_wrap,
    output logic [$clog2(FRAME_BITS)-1:0] bit_cnt
);
    localparam int CNT_W = $clog2(FRAME_BITS);
    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap;
    // Set while no falling edge has happened since reset or run start, so the
    // very first fall loads a frame and bit_cnt stays at 0 for that frame.
    logic             first;

    assign div_wrap   = (div_cnt == DIV_W'(BCLK_HALF - 1));
    assign fall_en    = run && div_wrap && bclk;
    assign frame_wrap = fall_en && (first || (bit_cnt == CNT_W'(FRAME_BITS - 1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            bit_cnt <= '0;
            first   <= 1'b1;
        end else if (!run) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            bit_cnt <= '0;
            first   <= 1'b1;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap) begin
                bclk <= ~bclk;
            end
            if (fall_en) begin
                first   <= 1'b0;
                bit_cnt <= frame_wrap ? '0 : bit_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/dac_dsp_serializer.sv
// WM8731 DSP-mode DAC serializer: one mono sample per frame sent on left and right slots, MSB first.
// Latency: a sample accepted >=1 clk before a frame load appears from that frame's bit 0 (< 1 frame + 1 clk).
// Backpressure: single holding register; s_ready = !hold_full, emptied by each frame load.
// Ports: clk, reset (async, active-low), run, s (sample stream slave); bclk, dac_lrck, dac_data,
//        frame_start, underflow out.
// Build option: DAC_UNDERFLOW_HOLD_EN repeats the last sent sample on underflow instead of silence.
module dac_dsp_serializer
    import dac_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int BCLK_HALF  = BCLK_HALF_DEF
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    dac_dsp_serializer_if.slave   s,
    output logic                  bclk,
    output logic                  dac_lrck,
    output logic                  dac_data,
    output logic                  frame_start,
    output logic                  underflow
);
    localparam int CNT_W = $clog2(FRAME_BITS);

    logic                  fall_en;
    logic                  frame_wrap;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_W-1:0]     hold_reg;
    logic                  hold_full;
    logic                  accept;
    logic [DATA_W-1:0]     load_sample;
    logic [FRAME_BITS-1:0] load_word;
    logic [FRAME_BITS-1:0] shift_reg;

    dac_bclk_gen #(
        .FRAME_BITS (FRAME_BITS),
        .BCLK_HALF  (BCLK_HALF)
    ) u_bclk_gen (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .bclk       (bclk),
        .fall_en    (fall_en),
        .frame_wrap (frame_wrap),
        .bit_cnt    (bit_cnt)
    );

    assign s.s_ready = !hold_full;
    assign accept    = s.s_valid && !hold_full;
    assign dac_data  = shift_reg[FRAME_BITS-1];

`ifdef DAC_UNDERFLOW_HOLD_EN
    logic [DATA_W-1:0] last_sample;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_sample <= '0;
        end else if (frame_wrap && hold_full) begin
            last_sample <= hold_reg;
        end
    end

    assign load_sample = hold_full ? hold_reg : last_sample;
`else
    assign load_sample = hold_full ? hold_reg : '0;
`endif

    // Same word in both slots, left-justified; slot bits past 2*DATA_W stay 0.
    always_comb begin
        load_word = '0;
        load_word[FRAME_BITS-1 -: 2*DATA_W] = {load_sample, load_sample};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_reg    <= '0;
            hold_full   <= 1'b0;
            shift_reg   <= '0;
            dac_lrck    <= 1'b0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            frame_start <= frame_wrap;
            underflow   <= frame_wrap && !hold_full;

            // A load only drains a full register; an underflowing load can
            // coincide with an accept, and that sample waits for the next frame.
            if (frame_wrap && hold_full) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_reg  <= s.s_data;
                hold_full <= 1'b1;
            end

            if (!run) begin
                shift_reg <= '0;
                dac_lrck  <= 1'b0;
            end else if (fall_en) begin
                shift_reg <= frame_wrap ? load_word : {shift_reg[FRAME_BITS-2:0], 1'b0};
                // High for the BCLK period in which bit_cnt sits at its last value.
                dac_lrck  <= !frame_wrap && (bit_cnt == CNT_W'(FRAME_BITS - 2));
            end
        end
    end
endmodule

// File: tb/tb_dac_dsp_serializer.sv
module tb_dac_dsp_serializer;
    import dac_pkg::*;

    localparam int DW = DATA_W_DEF;
    localparam int FB = FRAME_BITS_DEF;
    localparam int BH = BCLK_HALF_DEF;
    localparam int BP = 2 * BH;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic run = 1'b0;
    logic bclk, dac_lrck, dac_data, frame_start, underflow;

    dac_dsp_serializer_if #(.DATA_W(DW)) sif ();

    dac_dsp_serializer #(
        .DATA_W     (DW),
        .FRAME_BITS (FB),
        .BCLK_HALF  (BH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .s           (sif),
        .bclk        (bclk),
        .dac_lrck    (dac_lrck),
        .dac_data    (dac_data),
        .frame_start (frame_start),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: time since run start in clk edges, a one-deep holding slot,
    // and the word that the current frame carries.
    int      k = 0;
    bit      m_full = 0;
    sample_t m_hold = '0;
    sample_t m_last = '0;
    sample_t m_frame = '0;
    bit      m_load, m_acc;
    int      load_cnt = 0;
    logic [FB-1:0] cur_cap;
    logic [FB-1:0] capw [int];
    logic          capu [int];

    task automatic step();
        bit pre_full;
        int b;
        logic e_bclk, e_lrck, e_data, e_fs, e_uf;
        m_load = 0;
        m_acc  = 0;
        e_uf   = 0;
        if (!reset) begin
            k = 0; m_full = 0; m_hold = '0; m_last = '0; m_frame = '0;
        end else begin
            pre_full = m_full;
            if (!run) begin
                k = 0;
            end else begin
                k++;
                if ((k % BP) == 0 && ((k / BP - 1) % FB) == 0) begin
                    m_load = 1;
                    load_cnt++;
                    if (pre_full) begin
                        m_frame = m_hold; m_last = m_hold; m_full = 0;
                    end else begin
                        e_uf = 1;
`ifdef DAC_UNDERFLOW_HOLD_EN
                        m_frame = m_last;
`else
                        m_frame = '0;
`endif
                    end
                end
            end
            if (sif.s_valid && !pre_full) begin
                m_hold = sif.s_data; m_full = 1; m_acc = 1;
            end
        end
        e_bclk = 0; e_lrck = 0; e_data = 0; e_fs = m_load;
        if (reset && run) begin
            e_bclk = ((k / BH) % 2) == 1;
            if (k >= BP) begin
                b = (k / BP - 1) % FB;
                e_lrck = (b == FB - 1);
                e_data = (b < 2 * DW) ? m_frame[DW - 1 - (b % DW)] : 1'b0;
                if ((k % BP) == 0) begin
                    if (b == 0) cur_cap = '0;
                    cur_cap[FB - 1 - b] = dac_data;
                    if (b == FB - 1) capw[load_cnt - 1] = cur_cap;
                end
            end
        end
        if (m_load) capu[load_cnt - 1] = underflow;
        chk("outputs{bclk,lrck,data,fs,uf,rdy}",
            {58'd0, bclk, dac_lrck, dac_data, frame_start, underflow, sif.s_ready},
            {58'd0, e_bclk, e_lrck, e_data, e_fs, e_uf, !m_full});
    endtask

    task automatic tick();
        @(negedge clk);
        step();
    endtask

    function automatic bit preload();
        return reset && run && ((k + 1) % BP) == 0 && (((k + 1) / BP - 1) % FB) == 0;
    endfunction

    typedef struct {
        sample_t       sample;
        bit            feed;
        logic [FB-1:0] exp_word;
        logic          exp_uf;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int base, id1, cnt, ufs, exp_ufs;
        bit ok;
        sample_t hs;

        tbl[0] = '{16'hA5C3, 1'b1, 32'hA5C3_A5C3, 1'b0};
        tbl[1] = '{16'h8001, 1'b1, 32'h8001_8001, 1'b0};
        tbl[2] = '{16'h7FFE, 1'b1, 32'h7FFE_7FFE, 1'b0};
        tbl[3] = '{16'h1234, 1'b1, 32'h1234_1234, 1'b0};
`ifdef DAC_UNDERFLOW_HOLD_EN
        tbl[4] = '{16'h0000, 1'b0, 32'h1234_1234, 1'b1};
`else
        tbl[4] = '{16'h0000, 1'b0, 32'h0000_0000, 1'b1};
`endif
        tbl[5] = '{16'h0F0F, 1'b1, 32'h0F0F_0F0F, 1'b0};

        // Table frames: reset with run=1 and the first sample already valid.
        run = 1'b1;
        sif.s_valid = 1'b1;
        sif.s_data  = tbl[0].sample;
        #1;
        chk("reset state", {58'd0, bclk, dac_lrck, dac_data, frame_start, underflow, sif.s_ready},
            64'h1);
        repeat (3) tick();
        reset = 1'b1;
        base = load_cnt;
        ufs = 0;
        for (int c = 0; c < 6 * FB * BP + 200 && !capw.exists(base + 5); c++) begin
            tick();
            if (underflow) ufs++;
            if (m_acc) sif.s_valid = 1'b0;
            if (m_load && (load_cnt - base) < 6 && tbl[load_cnt - base].feed) begin
                sif.s_valid = 1'b1;
                sif.s_data  = tbl[load_cnt - base].sample;
            end
        end
        exp_ufs = 0;
        for (int j = 0; j < 6; j++) begin
            if (!tbl[j].feed) exp_ufs++;
            chk($sformatf("table frame %0d word", j),
                capw.exists(base + j) ? 64'(capw[base + j]) : 64'hDEAD, 64'(tbl[j].exp_word));
            chk($sformatf("table frame %0d underflow", j),
                capu.exists(base + j) ? 64'(capu[base + j]) : 64'hDEAD, 64'(tbl[j].exp_uf));
        end
        chk("table underflow pulse count", 64'(ufs), 64'(exp_ufs));

        // s_valid in the exact load cycle while the holding register is full.
        ok = 0;
        for (int c = 0; c < FB * BP + 10 && !ok; c++) begin tick(); ok = m_load; end
        chk("wait load before late-valid", 64'(ok), 64'd1);
        sif.s_valid = 1'b1; sif.s_data = 16'h5A3C;
        tick();
        sif.s_valid = 1'b0;
        for (int c = 0; c < FB * BP + 10 && !preload(); c++) tick();
        sif.s_valid = 1'b1; sif.s_data = 16'hC33C;
        tick();
        id1 = load_cnt - 1;
        chk("late-valid load cycle flags {load,ready}", {62'd0, frame_start, sif.s_ready}, 64'h3);
        tick();
        chk("late-valid accepted next cycle (ready)", 64'(sif.s_ready), 64'd0);
        sif.s_valid = 1'b0;
        for (int c = 0; c < 2 * FB * BP + 10 && !capw.exists(id1 + 1); c++) tick();
        chk("late-valid frame A", capw.exists(id1) ? 64'(capw[id1]) : 64'hDEAD, 64'h5A3C_5A3C);
        chk("late-valid frame B", capw.exists(id1 + 1) ? 64'(capw[id1 + 1]) : 64'hDEAD,
            64'hC33C_C33C);

        // Async reset in the middle of a frame at bit 10.
        for (int c = 0; c < FB * BP + 10 &&
             !(reset && run && k >= BP && (k % BP) == 0 && ((k / BP - 1) % FB) == 10); c++) tick();
        #2 reset = 1'b0;
        #1;
        chk("mid-frame reset outputs", {58'd0, bclk, dac_lrck, dac_data, frame_start, underflow,
            sif.s_ready}, 64'h1);
        tick();
        tick();
        reset = 1'b1;
        chk("ready after reset release", 64'(sif.s_ready), 64'd1);
        cnt = 0;
        for (int c = 0; c < 100 && !frame_start; c++) begin tick(); cnt++; end
        chk("first load after reset (clk cycles)", 64'(cnt), 64'(BP));

        // run=0 for three frames with a sample held.
        run = 1'b0;
        sif.s_valid = 1'b1; sif.s_data = 16'hC0DE;
        cnt = 0;
        for (int c = 0; c < 3 * FB * BP; c++) begin
            tick();
            if (m_acc) sif.s_valid = 1'b0;
            if (bclk) cnt++;
        end
        chk("bclk high cycles while idle", 64'(cnt), 64'd0);
        run = 1'b1;
        ok = 0;
        for (int c = 0; c < BP + 4 && !ok; c++) begin tick(); ok = m_load; end
        chk("load after run start", 64'(ok), 64'd1);
        id1 = load_cnt - 1;
        for (int c = 0; c < FB * BP + 10 && !capw.exists(id1); c++) tick();
        chk("held sample after idle", capw.exists(id1) ? 64'(capw[id1]) : 64'hDEAD, 64'hC0DE_C0DE);
        chk("held sample no underflow", 64'(capu[id1]), 64'd0);

        // Random traffic with gaps and occasional run toggles.
        for (int c = 0; c < 5000; c++) begin
            tick();
            if (m_acc) sif.s_valid = 1'b0;
            if (!sif.s_valid && $urandom_range(0, 99) == 0) begin
                hs = sample_t'($urandom);
                sif.s_valid = 1'b1;
                sif.s_data  = hs;
            end
            if ($urandom_range(0, 1999) == 0) run = !run;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
